// File: rtl/pipe_control.sv
// pipe_control: DLX instruction decode in ID, load-use interlock, taken-branch
// flush and EX operand forwarding over three registered stages
// (ID/EX, EX/MEM, MEM/WB).
module pipe_control #(
    parameter int RA_W      = 5,
    parameter int LINK_REG  = 31,
    parameter bit INTERLOCK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_id,
    input  logic            valid_id,
    input  logic            taken_ex,
    output logic            stall,
    output logic            flush,
    output logic [31:0]     ex_ctl,
    output logic [7:0]      mem_ctl,
    output logic            wb_reg_wr,
    output logic [RA_W-1:0] wb_dest,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            hazard
);

    typedef struct packed {
        logic mem_wr;
        logic sb;
        logic sh;
        logic lb;
        logic lh;
        logic load_extend;
        logic mem_to_reg;
    } mem_bits_t;

    typedef struct packed {
        logic [31:0]     ex;
        mem_bits_t       mem;
        logic            reg_wr;
        logic [RA_W-1:0] dest;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            valid;
    } stage_t;

    stage_t          idex_q, idex_d;
    stage_t          exmem_q, exmem_d;
    stage_t          memwb_q, memwb_d;
    stage_t          dec;
    mem_bits_t       dec_mem;

    logic [5:0]      opcode;
    logic [5:0]      func_code;
    logic            is_rtype;
    logic            branch_z, branch_nz, jmp, jmp_r;
    logic            imm_inst, imm_extend, lhi, link;
    logic            reg_wr_raw, rs1_used, rs2_used;
    logic [RA_W-1:0] rs1_id, rs2_id, rd_id, dest_id;
    logic            hazard_raw;
    logic            unused_bits;

    assign opcode = inst_id[31:26];
    assign rs1_id = RA_W'(inst_id[25:21]);
    assign rs2_id = RA_W'(inst_id[20:16]);
    assign rd_id  = RA_W'(inst_id[15:11]);

    // The shift-amount field and the WB copies of operands/control are carried but never consumed
    assign unused_bits = ^{inst_id[10:6], memwb_q.ex, memwb_q.mem, memwb_q.rs1,
                           memwb_q.rs2, memwb_q.valid};

    // Decode the ID instruction through the DLX opcode table into a full stage record
    always_comb begin
        is_rtype   = (opcode == 6'h00) || (opcode == 6'h01);
        branch_z   = 1'b0;
        branch_nz  = 1'b0;
        jmp        = 1'b0;
        jmp_r      = 1'b0;
        imm_inst   = 1'b1;
        imm_extend = 1'b1;
        lhi        = 1'b0;
        link       = 1'b0;
        func_code  = inst_id[5:0];
        dec_mem    = '0;
        dec_mem.load_extend = 1'b1;
        reg_wr_raw = 1'b1;
        rs1_used   = 1'b1;
        rs2_used   = 1'b0;
        case (opcode)
            6'h00, 6'h01: begin imm_inst = 1'b0; rs2_used = 1'b1; end
            6'h02: begin jmp = 1'b1; reg_wr_raw = 1'b0; rs1_used = 1'b0; end
            6'h03: begin jmp = 1'b1; link = 1'b1; rs1_used = 1'b0; end
            6'h04: begin branch_z = 1'b1; reg_wr_raw = 1'b0; end
            6'h05: begin branch_nz = 1'b1; reg_wr_raw = 1'b0; end
            6'h08: func_code = 6'h20;
            6'h09: func_code = 6'h21;
            6'h0a: func_code = 6'h22;
            6'h0b: func_code = 6'h23;
            6'h0c: begin func_code = 6'h24; imm_extend = 1'b0; end
            6'h0d: begin func_code = 6'h25; imm_extend = 1'b0; end
            6'h0e: begin func_code = 6'h26; imm_extend = 1'b0; end
            6'h0f: begin lhi = 1'b1; rs1_used = 1'b0; end
            6'h12: begin jmp_r = 1'b1; reg_wr_raw = 1'b0; end
            6'h13: begin jmp_r = 1'b1; link = 1'b1; end
            6'h14: func_code = 6'h04;
            6'h16: func_code = 6'h06;
            6'h17: func_code = 6'h07;
            6'h18: func_code = 6'h28;
            6'h19: func_code = 6'h29;
            6'h1a: func_code = 6'h2a;
            6'h1b: func_code = 6'h2b;
            6'h1c: func_code = 6'h2c;
            6'h1d: func_code = 6'h2d;
            6'h20: begin dec_mem.lb = 1'b1; dec_mem.mem_to_reg = 1'b1; func_code = 6'h20; end
            6'h21: begin dec_mem.lh = 1'b1; dec_mem.mem_to_reg = 1'b1; func_code = 6'h20; end
            6'h23: begin dec_mem.mem_to_reg = 1'b1; func_code = 6'h20; end
            6'h24: begin
                dec_mem.lb = 1'b1; dec_mem.load_extend = 1'b0;
                dec_mem.mem_to_reg = 1'b1; func_code = 6'h20;
            end
            6'h25: begin
                dec_mem.lh = 1'b1; dec_mem.load_extend = 1'b0;
                dec_mem.mem_to_reg = 1'b1; func_code = 6'h20;
            end
            6'h28: begin
                dec_mem.mem_wr = 1'b1; dec_mem.sb = 1'b1;
                reg_wr_raw = 1'b0; rs2_used = 1'b1; func_code = 6'h20;
            end
            6'h29: begin
                dec_mem.mem_wr = 1'b1; dec_mem.sh = 1'b1;
                reg_wr_raw = 1'b0; rs2_used = 1'b1; func_code = 6'h20;
            end
            6'h2b: begin
                dec_mem.mem_wr = 1'b1;
                reg_wr_raw = 1'b0; rs2_used = 1'b1; func_code = 6'h20;
            end
            default: ;
        endcase

        if (is_rtype)
            dest_id = rd_id;
        else if (link)
            dest_id = RA_W'(LINK_REG);
        else
            dest_id = rs2_id;

        dec.ex     = {branch_z, branch_nz, jmp, jmp_r, imm_inst, imm_extend, lhi, link,
                      func_code, 18'd0};
        dec.mem    = dec_mem;
        dec.reg_wr = reg_wr_raw && (dest_id != '0);
        dec.dest   = dest_id;
        dec.rs1    = rs1_id;
        dec.rs2    = rs2_id;
        dec.valid  = 1'b1;
    end

    // Load-use detection against the load sitting in EX; a taken branch overrides the stall
    always_comb begin
        hazard_raw = idex_q.valid && idex_q.mem.mem_to_reg && (idex_q.dest != '0) && valid_id &&
                     ((rs1_used && (idex_q.dest == rs1_id)) ||
                      (rs2_used && (idex_q.dest == rs2_id)));
        hazard = hazard_raw && !rst;
        flush  = taken_ex && !rst;
        stall  = INTERLOCK && hazard_raw && !taken_ex && !rst;
    end

    // Next stage contents: ID/EX takes a bubble on flush, stall or empty ID; later stages always advance
    always_comb begin
        idex_d = dec;
        if (taken_ex || !valid_id || stall)
            idex_d = '0;
        exmem_d = idex_q;
        memwb_d = exmem_q;
    end

    // Stage registers; reset fills every stage with a bubble immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // Operand source selection for EX; the younger MEM-stage result wins over WB
    always_comb begin
        fwd_a = 2'b00;
        if (exmem_q.reg_wr && (exmem_q.dest != '0) && (exmem_q.dest == idex_q.rs1))
            fwd_a = 2'b01;
        else if (memwb_q.reg_wr && (memwb_q.dest != '0) && (memwb_q.dest == idex_q.rs1))
            fwd_a = 2'b10;
        fwd_b = 2'b00;
        if (exmem_q.reg_wr && (exmem_q.dest != '0) && (exmem_q.dest == idex_q.rs2))
            fwd_b = 2'b01;
        else if (memwb_q.reg_wr && (memwb_q.dest != '0) && (memwb_q.dest == idex_q.rs2))
            fwd_b = 2'b10;
    end

    assign ex_ctl    = idex_q.ex;
    assign mem_ctl   = {exmem_q.mem, exmem_q.valid};
    assign wb_reg_wr = memwb_q.reg_wr;
    assign wb_dest   = memwb_q.dest;

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter RA_W, default 5: register-address width; fields are inst[25:21] rs1, inst[20:16] rs2/rt, inst[15:11] rd.
REQ-002 Parameter LINK_REG, default 31: destination register for JAL/JALR.
REQ-003 Parameter INTERLOCK, default 1: 1 = load-use stall inserted; 0 = no stall, hazard only flagged.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 inst_id  in  32  instruction in ID stage.
REQ-007 valid_id  in  1  inst_id is a real instruction.
REQ-008 taken_ex  in  1  datapath resolved branch/jump in EX as taken.
REQ-009 stall  out  1  hold PC and IF/ID register this cycle.
REQ-010 flush  out  1  invalidate IF/ID register this cycle.
REQ-011 ex_ctl  out  32  registered EX control bundle {branch_z, branch_nz, jmp, jmp_r, imm_inst, imm_extend, lhi, link, func_code[5:0], padding zeros}.
REQ-012 mem_ctl  out  8  registered MEM bundle {mem_wr, sb, sh, lb, lh, load_extend, mem_to_reg, valid}.
REQ-013 wb_reg_wr  out  1; wb_dest  out  RA_W: WB-stage write enable and destination.
REQ-014 fwd_a, fwd_b  out  2 each: EX operand source, 00 register file, 01 MEM-stage result, 10 WB-stage result.
REQ-015 hazard  out  1  combinational load-use hazard detected this cycle.

Function
REQ-016 Decode in ID SHALL use the DLX opcode table: stores 0x28/0x29/0x2b set mem_wr; loads 0x20/0x21/0x23/0x24/0x25 set mem_to_reg; 0x24/0x25 clear load_extend; 0x0c-0x0e clear imm_extend; opcodes 0x00/0x01 are R-type (imm_inst=0, func_code=inst[5:0]); immediate ALU opcodes map to func_code per the DLX table (ADDI->0x20 ... SGEI->0x2d, SLLI->0x04, SRLI->0x06, SRAI->0x07); 0x0f sets lhi; 0x03 and 0x13 set link.
REQ-017 reg_wr SHALL be 0 for J (0x02), JR (0x12), BEQZ (0x04), BNEZ (0x05), all stores; 1 otherwise; forced 0 when dest==0.
REQ-018 Destination: rd for R-type, LINK_REG for link, rt otherwise.
REQ-019 Use flags: rs1 used unless J/JAL/LHI; rs2 used for R-type and stores only.
REQ-020 Pipeline SHALL be three registered stages ID/EX, EX/MEM, MEM/WB; each holds control bundle, dest, rs1, rs2, valid.
REQ-021 Bubble = all control bits 0, valid 0, dest 0.
REQ-022 hazard = ID/EX valid & mem_to_reg & dest!=0 & ((rs1 used & dest==rs1_id) | (rs2 used & dest==rs2_id)) & valid_id.
REQ-023 INTERLOCK=1: hazard SHALL assert stall and load a bubble into ID/EX, exactly one cycle per hazard; EX/MEM and MEM/WB advance normally.
REQ-024 INTERLOCK=0: stall SHALL stay 0; hazard still reported.
REQ-025 taken_ex SHALL assert flush and load a bubble into ID/EX next edge; flush has priority over stall (stall forced 0 when taken_ex).
REQ-026 valid_id=0 SHALL load a bubble into ID/EX.
REQ-027 fwd_x = 01 if EX/MEM reg_wr & dest!=0 & dest==rsx_ex; else 10 if MEM/WB reg_wr & dest!=0 & dest==rsx_ex; else 00; MEM priority over WB.
REQ-028 Latency: ID decode to ex_ctl 1 cycle, mem_ctl 2 cycles, wb_* 3 cycles.
REQ-029 Undefined opcodes SHALL decode as reg_wr=1 ALU op with func_code=inst[5:0].

Reset
REQ-030 While rst=1 all three stage registers SHALL hold bubbles immediately (asynchronous); ex_ctl=0, mem_ctl=0, wb_reg_wr=0, wb_dest=0, fwd_a=fwd_b=00.
REQ-031 stall, flush, hazard SHALL be 0 during reset.
REQ-032 Reset deasserted mid-stall SHALL leave no stall pending; first edge after release captures inst_id normally.

Verification
REQ-033 LW r5,0(r1) then ADD r6,r5,r2 -> hazard=1, stall=1 one cycle, ID/EX bubble, then fwd_a=10 for ADD in EX.
REQ-034 ADD r3,r1,r2 then SUB r4,r3,r3 -> no stall, fwd_a=fwd_b=01.
REQ-035 BEQZ in EX with taken_ex=1 while load-use hazard in ID -> flush=1, stall=0, ID/EX bubble.
REQ-036 JAL -> wb_dest=31, wb_reg_wr=1 three cycles later; ADD r0,r1,r2 -> wb_reg_wr=0.
REQ-037 ORI opcode 0x0d -> ex_ctl imm_extend=0, func_code=0x25; LBU -> mem_ctl load_extend=0, mem_to_reg=1.
REQ-038 rst asserted asynchronously mid-pipeline with three valid instructions -> all outputs 0 before next clock edge.
